// File: rtl/watch_pkg.sv
// Shared watch constants: controller state encoding and default button/blink timing.
// Latency: n/a, constants and types only.
// Backpressure: n/a.
package watch_pkg;

   // Top-level clock frequency; all default timing below is derived from it.
   localparam int CLK_FREQ_HZ    = 100_000_000;

   localparam int DEF_HOLD_DLY   = CLK_FREQ_HZ / 2;   // 0.5 s before auto-repeat
   localparam int DEF_REPEAT_PER = CLK_FREQ_HZ / 10;  // 10 repeats per second
   localparam int DEF_TIMEOUT    = CLK_FREQ_HZ * 5;   // 5 s of inactivity leaves SET
   localparam int DEF_BLINK_HALF = CLK_FREQ_HZ / 4;   // 2 Hz blink

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_SET   = 2'b10,
      ST_CLEAR = 2'b11
   } state_e;

endpackage

// File: rtl/btn_auto_repeat.sv
// Held-button auto-repeat: pulse on press, again after HOLD_DLY, then every REPEAT_PER.
// Latency: o_pulse is combinational in the cycle the press/repeat point is sampled.
// Backpressure: none; i_en low clears the repeat state and looks like a release.
module btn_auto_repeat #(
   parameter int HOLD_DLY   = watch_pkg::DEF_HOLD_DLY,
   parameter int REPEAT_PER = watch_pkg::DEF_REPEAT_PER
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int CNT_MAX = (HOLD_DLY > REPEAT_PER) ? HOLD_DLY : REPEAT_PER;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DLY);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PER);

   logic             btn_q, btn_d;
   logic             rep_q, rep_d;   // 0: waiting out the hold delay, 1: repeating
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse;

   // Edge detect plus hold/repeat interval counter; disabled means released.
   always_comb begin
      btn_d = 1'b0;
      rep_d = 1'b0;
      cnt_d = '0;
      pulse = 1'b0;
      if (i_en) begin
         btn_d = i_btn;
         if (i_btn && !btn_q) begin
            pulse = 1'b1;
            cnt_d = CNT_W'(1);
         end else if (i_btn) begin
            if (cnt_q == (rep_q ? REP_LAST : HOLD_LAST)) begin
               pulse = 1'b1;
               cnt_d = CNT_W'(1);
               rep_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               rep_d = rep_q;
            end
         end
      end
   end

   // Repeat state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_q <= 1'b0;
         rep_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         btn_q <= btn_d;
         rep_q <= rep_d;
         cnt_q <= cnt_d;
      end
   end

   assign o_pulse = pulse;

endmodule

// File: rtl/time_set_ctrl.sv
// Watch run/clear control with interactive time setting: cursor, auto-repeat inc/dec, timeout, blink.
// Latency: every output is registered, reflecting inputs sampled at the previous clock edge.
// Backpressure: none; i_mode_sel low freezes state and suppresses inc/dec pulses.
module time_set_ctrl
   import watch_pkg::*;
#(
   parameter int N_FIELDS   = 4,
   parameter int HOLD_DLY   = DEF_HOLD_DLY,
   parameter int REPEAT_PER = DEF_REPEAT_PER,
   parameter int TIMEOUT    = DEF_TIMEOUT,
   parameter int BLINK_HALF = DEF_BLINK_HALF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_mode_sel,
   input  logic                i_run,
   input  logic                i_setting,
   input  logic                i_clear,
   input  logic                i_btn_up,
   input  logic                i_btn_down,
   input  logic                i_btn_left,
   input  logic                i_btn_right,
   output logic                o_run,
   output logic                o_clear,
   output logic                o_setting,
   output logic [N_FIELDS-1:0] o_field_sel,
   output logic                o_inc,
   output logic                o_dec,
   output logic                o_blink
);

   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam int BL_W = $clog2(BLINK_HALF + 1);
   localparam logic [TO_W-1:0]     TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [BL_W-1:0]     BL_LAST = BL_W'(BLINK_HALF - 1);
   localparam logic [N_FIELDS-1:0] CUR_RST = N_FIELDS'(1) << (N_FIELDS - 1);

   state_e              state_q, state_d;
   logic [N_FIELDS-1:0] cursor_q, cursor_d;
   logic                arm_q, arm_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [BL_W-1:0]     blink_cnt_q, blink_cnt_d;
   logic                blink_q, blink_d;

   logic                run_q, run_d;
   logic                clear_q, clear_d;
   logic                setting_q, setting_d;
   logic [N_FIELDS-1:0] field_sel_q, field_sel_d;
   logic                inc_q, inc_d;
   logic                dec_q, dec_d;
   logic                blink_out_q, blink_out_d;

   logic                activity;
   logic                rep_en;
   logic                up_pulse;
   logic                dn_pulse;

   assign activity = i_btn_up | i_btn_down | i_btn_left | i_btn_right;

   // Both directions held at once cancels both and restarts their repeat timing.
   assign rep_en = i_mode_sel && (state_q == ST_SET) && !(i_btn_up && i_btn_down);

   btn_auto_repeat #(
      .HOLD_DLY   (HOLD_DLY),
      .REPEAT_PER (REPEAT_PER)
   ) u_rep_up (
      .clk     (clk),
      .reset   (reset),
      .i_en    (rep_en),
      .i_btn   (i_btn_up),
      .o_pulse (up_pulse)
   );

   btn_auto_repeat #(
      .HOLD_DLY   (HOLD_DLY),
      .REPEAT_PER (REPEAT_PER)
   ) u_rep_dn (
      .clk     (clk),
      .reset   (reset),
      .i_en    (rep_en),
      .i_btn   (i_btn_down),
      .o_pulse (dn_pulse)
   );

   // Next state and arm flag; a pending CLEAR finishes even when the buttons are not ours.
   always_comb begin
      state_d = state_q;
      arm_d   = arm_q;
      if (i_mode_sel) begin
         case (state_q)
            ST_IDLE: begin
               if (i_setting && arm_q)  state_d = ST_SET;
               else if (i_run)          state_d = ST_RUN;
            end
            ST_RUN: begin
               if (i_setting && arm_q)  state_d = ST_SET;
               else if (i_clear)        state_d = ST_CLEAR;
            end
            ST_SET: begin
               if (!i_setting)          state_d = ST_RUN;
               else if (i_clear)        state_d = ST_CLEAR;
               else if (to_cnt_q == TO_LAST) begin
                  // Disarm so the still-high switch cannot re-enter SET at once.
                  state_d = ST_RUN;
                  arm_d   = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
         if (!i_setting) arm_d = 1'b1;
      end else if (state_q == ST_CLEAR) begin
         state_d = ST_IDLE;
      end
   end

   // Cursor rotation; only moves while setting, and is kept across SET exits.
   always_comb begin
      cursor_d = cursor_q;
      if (i_mode_sel && (state_q == ST_SET) && (i_btn_left != i_btn_right)) begin
         if (i_btn_left) cursor_d = (cursor_q << 1) | (cursor_q >> (N_FIELDS - 1));
         else            cursor_d = (cursor_q >> 1) | (cursor_q << (N_FIELDS - 1));
      end
   end

   // Inactivity timer: counts quiet cycles spent in SET, restarts on entry or any button.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (i_mode_sel) begin
         if ((state_q != ST_SET) || (state_d != ST_SET)) to_cnt_d = '0;
         else if (activity)                              to_cnt_d = '0;
         else                                            to_cnt_d = to_cnt_q + TO_W'(1);
      end
   end

   // Blink phase: starts lit on SET entry, toggles every BLINK_HALF cycles.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      if (i_mode_sel) begin
         if ((state_q != ST_SET) && (state_d == ST_SET)) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
         end else if (state_q == ST_SET) begin
            if (blink_cnt_q == BL_LAST) begin
               blink_cnt_d = '0;
               blink_d     = ~blink_q;
            end else begin
               blink_cnt_d = blink_cnt_q + BL_W'(1);
            end
         end
      end
   end

   // Output decode from the next state so outputs line up with the state register.
   always_comb begin
      run_d       = (state_d == ST_RUN);
      clear_d     = (state_d == ST_CLEAR);
      setting_d   = (state_d == ST_SET);
      field_sel_d = setting_d ? cursor_d : '0;
      blink_out_d = setting_d & blink_d;
      inc_d       = setting_d & up_pulse;
      dec_d       = setting_d & dn_pulse;
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cursor_q    <= CUR_RST;
         arm_q       <= 1'b1;
         to_cnt_q    <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
         run_q       <= 1'b0;
         clear_q     <= 1'b0;
         setting_q   <= 1'b0;
         field_sel_q <= '0;
         inc_q       <= 1'b0;
         dec_q       <= 1'b0;
         blink_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cursor_q    <= cursor_d;
         arm_q       <= arm_d;
         to_cnt_q    <= to_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
         run_q       <= run_d;
         clear_q     <= clear_d;
         setting_q   <= setting_d;
         field_sel_q <= field_sel_d;
         inc_q       <= inc_d;
         dec_q       <= dec_d;
         blink_out_q <= blink_out_d;
      end
   end

   assign o_run       = run_q;
   assign o_clear     = clear_q;
   assign o_setting   = setting_q;
   assign o_field_sel = field_sel_q;
   assign o_inc       = inc_q;
   assign o_dec       = dec_q;
   assign o_blink     = blink_out_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: vector table, hand-written corner sequences, randomized model check.
// Latency: outputs checked 1 time unit after each rising clock edge.
// Backpressure: n/a.
module tb_time_set_ctrl;

   localparam int NF    = 4;
   localparam int HOLD  = 8;
   localparam int REP   = 4;
   localparam int TOUT  = 40;
   localparam int BLINK = 5;

   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_SET  = 2;
   localparam int S_CLR  = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mode, run, setting, clear, up, dn, left, right;
   logic          o_run, o_clear, o_setting, o_inc, o_dec, o_blink;
   logic [NF-1:0] o_field_sel;
   logic [9:0]    dut_out;

   int n_checks = 0;
   int n_fail   = 0;
   bit model_on = 1'b0;

   always #5 clk = ~clk;

   time_set_ctrl #(
      .N_FIELDS   (NF),
      .HOLD_DLY   (HOLD),
      .REPEAT_PER (REP),
      .TIMEOUT    (TOUT),
      .BLINK_HALF (BLINK)
   ) dut (
      .clk         (clk),
      .reset       (rst_n),
      .i_mode_sel  (mode),
      .i_run       (run),
      .i_setting   (setting),
      .i_clear     (clear),
      .i_btn_up    (up),
      .i_btn_down  (dn),
      .i_btn_left  (left),
      .i_btn_right (right),
      .o_run       (o_run),
      .o_clear     (o_clear),
      .o_setting   (o_setting),
      .o_field_sel (o_field_sel),
      .o_inc       (o_inc),
      .o_dec       (o_dec),
      .o_blink     (o_blink)
   );

   // {run, clear, setting, field_sel[3:0], inc, dec, blink}
   assign dut_out = {o_run, o_clear, o_setting, o_field_sel, o_inc, o_dec, o_blink};

   // ---------------- reference model ----------------
   int       m_st, m_cur, m_quiet, m_age, m_up, m_dn;
   bit       m_arm;
   bit [9:0] m_exp;

   function automatic int next_age(input bit en, input bit btn, input int age);
      if (!en || !btn) return -1;
      return (age < 0) ? 0 : age + 1;
   endfunction

   function automatic bit fires(input int age);
      return (age == 0) || (age == HOLD) || (age > HOLD && ((age - HOLD) % REP) == 0);
   endfunction

   task automatic model_reset();
      m_st = S_IDLE; m_cur = NF - 1; m_arm = 1'b1;
      m_quiet = 0; m_age = 0; m_up = -1; m_dn = -1;
      m_exp = '0;
   endtask

   task automatic model_step();
      int nx;
      bit en, act, pu, pd, in_set;
      nx  = m_st;
      act = up | dn | left | right;
      en  = mode && (m_st == S_SET) && !(up && dn);
      if (mode) begin
         case (m_st)
            S_IDLE: if (setting && m_arm) nx = S_SET; else if (run) nx = S_RUN;
            S_RUN:  if (setting && m_arm) nx = S_SET; else if (clear) nx = S_CLR;
            S_SET: begin
               if (!setting) nx = S_RUN;
               else if (clear) nx = S_CLR;
               else if (m_quiet == TOUT - 1) begin nx = S_RUN; m_arm = 1'b0; end
            end
            default: nx = S_IDLE;
         endcase
         if (!setting) m_arm = 1'b1;
         if (m_st == S_SET && left != right)
            m_cur = left ? (m_cur + 1) % NF : (m_cur + NF - 1) % NF;
         m_quiet = (m_st == S_SET && nx == S_SET && !act) ? m_quiet + 1 : 0;
         if (m_st != S_SET && nx == S_SET) m_age = 0;
         else if (m_st == S_SET) m_age = m_age + 1;
      end else if (m_st == S_CLR) begin
         nx = S_IDLE;
      end
      m_up = next_age(en, up, m_up);
      m_dn = next_age(en, dn, m_dn);
      pu = fires(m_up);
      pd = fires(m_dn);
      m_st = nx;
      in_set = (nx == S_SET);
      m_exp = {nx == S_RUN, nx == S_CLR, in_set,
               in_set ? 4'(1 << m_cur) : 4'b0000,
               pu && in_set, pd && in_set,
               in_set && ((m_age / BLINK) % 2 == 0)};
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      if (model_on) check("model", dut_out, m_exp);
   endtask

   task automatic set_in(input logic [7:0] v);
      {mode, run, setting, clear, up, dn, left, right} = v;
   endtask

   typedef struct packed {
      logic [7:0] in;   // mode run setting clear up dn left right
      logic [9:0] exp;  // run clear setting sel[3:0] inc dec blink
   } vec_t;

   vec_t tbl[15];

   initial begin
      bit exp_inc;

      tbl[0]  = '{8'b1100_0000, 10'b100_0000_000};
      tbl[1]  = '{8'b1000_0000, 10'b100_0000_000};
      tbl[2]  = '{8'b1001_0000, 10'b010_0000_000};
      tbl[3]  = '{8'b1000_0000, 10'b000_0000_000};
      tbl[4]  = '{8'b1000_0000, 10'b000_0000_000};
      tbl[5]  = '{8'b1010_0000, 10'b001_1000_001};
      tbl[6]  = '{8'b1010_0001, 10'b001_0100_001};
      tbl[7]  = '{8'b1010_0001, 10'b001_0010_001};
      tbl[8]  = '{8'b1010_0001, 10'b001_0001_001};
      tbl[9]  = '{8'b1010_0001, 10'b001_1000_001};
      tbl[10] = '{8'b1010_0010, 10'b001_0001_000};
      tbl[11] = '{8'b1010_0011, 10'b001_0001_000};
      tbl[12] = '{8'b1000_0000, 10'b100_0000_000};
      tbl[13] = '{8'b1000_0010, 10'b100_0000_000};
      tbl[14] = '{8'b1010_0000, 10'b001_0001_001};

      rst_n = 1'b0;
      set_in(8'b0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_state", dut_out, 10'b0);
      rst_n = 1'b1;

      // run / clear / cursor navigation vectors
      for (int i = 0; i < 15; i++) begin
         set_in(tbl[i].in);
         tick();
         check($sformatf("vec%0d", i), dut_out, tbl[i].exp);
      end

      // up held 20 cycles: pulses at offsets 1, 9, 13, 17
      set_in(8'b1010_1000);
      for (int i = 1; i <= 20; i++) begin
         tick();
         exp_inc = (i == 1) || (i == 9) || (i == 13) || (i == 17);
         check($sformatf("rep_up%0d", i), 10'({o_inc, o_dec}), 10'({exp_inc, 1'b0}));
      end
      // down joins: both suppressed
      set_in(8'b1010_1100);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("both_held", 10'({o_inc, o_dec}), 10'b0);
      end

      // inactivity timeout with switch still on
      set_in(8'b1010_0000);
      for (int i = 0; i < TOUT - 1; i++) tick();
      check("pre_timeout", 10'(o_setting), 10'd1);
      tick();
      check("timeout_exit", 10'({o_run, o_setting}), 10'b10);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("no_reentry", 10'(o_setting), 10'd0);
      end
      set_in(8'b1000_0000);
      tick();
      check("switch_off_run", 10'(o_run), 10'd1);
      set_in(8'b1010_0000);
      tick();
      check("reentry", dut_out, 10'b001_0001_001);

      // mode_sel low: down held, left and switch-off ignored, state frozen
      for (int i = 1; i <= 6; i++) begin
         set_in({1'b0, 1'b0, (i <= 3), 5'b0_0100 | ((i == 3) ? 5'b0_0010 : 5'b0)});
         tick();
         check($sformatf("mode_off%0d", i), dut_out, 10'b001_0001_001);
      end
      set_in(8'b1010_0100);
      tick();
      check("mode_restore_dec", dut_out, 10'b001_0001_011);
      tick();
      check("dec_single", dut_out, 10'b001_0001_001);

      // reset while up auto-repeats in SET
      set_in(8'b1010_1000);
      for (int i = 0; i < 10; i++) tick();
      rst_n = 1'b0;
      model_reset();
      #1;
      check("reset_async", dut_out, 10'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("reset_hold", dut_out, 10'b0);
      end
      rst_n = 1'b1;
      set_in(8'b1000_0000);
      tick();
      check("idle_after_reset", dut_out, 10'b0);
      set_in(8'b1010_0000);
      tick();
      check("cursor_after_reset", dut_out, 10'b001_1000_001);

      // randomized run against the reference model
      rst_n = 1'b0;
      set_in(8'b1000_0000);
      tick();
      tick();
      rst_n = 1'b1;
      model_on = 1'b1;
      for (int blk = 0; blk < 10; blk++) begin
         bit quiet;
         quiet = (blk % 2) == 1;
         for (int c = 0; c < 200; c++) begin
            mode  = ($urandom_range(0, 29) != 0);
            run   = ($urandom_range(0, 15) == 0);
            clear = ($urandom_range(0, quiet ? 149 : 19) == 0);
            if ($urandom_range(0, quiet ? 149 : 39) == 0) setting = !setting;
            left  = ($urandom_range(0, quiet ? 99 : 7) == 0);
            right = ($urandom_range(0, quiet ? 99 : 7) == 0);
            if (quiet) begin
               up = 1'b0;
               dn = 1'b0;
            end else begin
               if ($urandom_range(0, 24) == 0) up = !up;
               if ($urandom_range(0, 29) == 0) dn = !dn;
            end
            tick();
         end
      end
      model_on = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Parametrised control unit for the watch datapath: run/clear control plus an interactive time-setting mode. It drives one field-increment or field-decrement pulse at a time into the time counters.
- Adds N-field cursor navigation with left/right buttons.
- Adds held-button auto-repeat, an inactivity timeout that exits setting mode, and a blink strobe for the selected digits.
- Sits between the button debouncers/switches and the watch counter datapath / FND display controller.

Parameters:
- N_FIELDS, 4: number of editable fields; bit N_FIELDS-1 is the most significant field (hour), bit 0 the least (msec).
- HOLD_DLY, 50_000_000: clk cycles a button must be held before auto-repeat starts.
- REPEAT_PER, 10_000_000: clk cycles between auto-repeat pulses.
- TIMEOUT, 500_000_000: clk cycles of no button activity in SET before automatic exit.
- BLINK_HALF, 25_000_000: clk cycles per blink half-period.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- i_mode_sel  in  1  1 = watch unit owns the buttons; 0 = inputs ignored, state frozen
- i_run  in  1  single-cycle pulse: start from IDLE
- i_setting  in  1  level: setting switch
- i_clear  in  1  single-cycle pulse: clear request
- i_btn_up  in  1  debounced level
- i_btn_down  in  1  debounced level
- i_btn_left  in  1  single-cycle pulse: cursor toward MSB field
- i_btn_right  in  1  single-cycle pulse: cursor toward LSB field
- o_run  out  1  counters advance
- o_clear  out  1  one-cycle clear pulse
- o_setting  out  1  high while in SET
- o_field_sel  out  N_FIELDS  one-hot cursor; all zero outside SET
- o_inc  out  1  one-cycle increment pulse for the selected field
- o_dec  out  1  one-cycle decrement pulse for the selected field
- o_blink  out  1  blink strobe; 0 outside SET

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. All outputs are registered.
- Reset state: state=IDLE, cursor=N_FIELDS-1, all counters 0, arm=1, every output 0.
- State encoding: IDLE=2'b00, RUN=2'b01, SET=2'b10, CLEAR=2'b11.
- IDLE: if i_setting&arm go to SET; else if i_run go to RUN.
- RUN: o_run=1. If i_setting&arm go to SET; else if i_clear go to CLEAR.
- SET: o_run=0, o_setting=1. Transition priority:
  - !i_setting → RUN
  - else i_clear → CLEAR
  - else timeout expiry → RUN, with arm cleared
- CLEAR: o_clear=1 for exactly one cycle, then go to IDLE.
- arm: cleared on timeout exit; set again whenever i_setting is sampled 0. This stops a held switch from re-entering SET immediately after a timeout.
- Cursor (SET only):
  - i_btn_left rotates toward the MSB field, wrapping N_FIELDS-1 → 0.
  - i_btn_right rotates toward the LSB field, wrapping 0 → N_FIELDS-1.
  - Left and right in the same cycle: no move.
  - Cursor is retained across SET exits; only reset restores it.
- Inc/dec, per button, via the btn_auto_repeat sub-module:
  - Rising edge of the level gives a pulse 1 cycle later.
  - While held, next pulse comes HOLD_DLY cycles after the edge pulse, then one every REPEAT_PER cycles.
  - Release re-arms.
  - up and down both high: both suppressed, repeat counters cleared.
  - Pulses are gated to SET and i_mode_sel=1; never both in one cycle.
- Timeout counter: cleared on SET entry and on any up/down/left/right activity; increments otherwise. Expiry when it reaches TIMEOUT-1.
- Blink: on SET entry o_blink=1 and the counter clears. It toggles every BLINK_HALF cycles. Forced 0 outside SET.
- i_mode_sel=0:
  - State, cursor, arm and the timeout/blink counters hold.
  - Repeat counters clear; o_inc/o_dec are 0.
  - o_run, o_setting, o_field_sel and o_blink keep reflecting the held state, so the clock keeps running in the background.
  - A pending CLEAR still completes to IDLE.
- Counter widths: $clog2(param+1). Saturation is never reached, because each counter clears on expiry.
- Reset asserted mid-SET or mid-repeat: immediate return to the reset values, with no pulse emitted.

Decomposition:
- Shared package (watch_pkg): the state encoding constants and the default timing constants. The top-level clock frequency is defined here.
- One sub-module, btn_auto_repeat: parameters HOLD_DLY and REPEAT_PER; ports clk, reset, i_en, i_btn, o_pulse. Instantiated twice, once for up and once for down. The both-held suppression is done by driving i_en low on both instances.

Test Plan:
Bench parameters: N_FIELDS=4, HOLD_DLY=8, REPEAT_PER=4, TIMEOUT=40, BLINK_HALF=5.
- Reset then i_run pulse → o_run=1 next cycle. Then i_clear pulse → o_clear high exactly 1 cycle, state IDLE, o_run=0.
- i_setting=1 → o_field_sel=4'b1000, o_blink=1. i_btn_right ×4 → 0100, 0010, 0001, 1000 (wrap). i_btn_left once → 0001.
- In SET, hold i_btn_up for 20 cycles → o_inc pulses at offsets 1, 9, 13, 17; o_dec stays 0. Pressing down while up is held → no further pulses.
- In SET, idle 40 cycles with i_setting=1 → RUN and o_setting=0; no re-entry while i_setting stays 1. Toggle i_setting 0→1 → SET again.
- In SET, drop i_mode_sel to 0 and hold i_btn_down → no o_dec, state and cursor unchanged. Restore i_mode_sel → o_dec 1 cycle later.
- Assert reset mid-repeat in SET → all outputs 0 immediately. After release, state=IDLE and cursor=4'b1000 on the next SET entry.
